// File: rtl/tiny_platform_cosim_pkg.sv
// Shared types for the cosim data-side tracker: request entry and notify record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: AddrWidth/DataWidth/BeWidth constants, dside_req_t, dside_rec_t.
package tiny_platform_cosim_pkg;

    localparam int AddrWidth = 32;
    localparam int DataWidth = 32;

    // One byte-enable bit per data byte.
    function automatic int bew(input int dw);
        return dw / 8;
    endfunction

    localparam int BeWidth = bew(DataWidth);

    // Everything captured at grant time, held until the matching response.
    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [BeWidth-1:0]   be;
        logic [DataWidth-1:0] wdata;
        logic                 mis1;
        logic                 mis2;
    } dside_req_t;

    // Record handed to the cosim shim once per completed access.
    typedef struct packed {
        logic                 store;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
        logic [BeWidth-1:0]   be;
        logic                 err;
        logic                 mis1;
        logic                 mis2;
    } dside_rec_t;

endpackage

// File: rtl/tiny_platform_dside_tracker_if.sv
// Snooped OBI-style dmem bus, one lane per channel.
// Latency: n/a (wires only).
// Backpressure: none; the tracker only observes, it never stalls the bus.
// master: drives the bus (host/bench); slave: observes it (tracker).
interface tiny_platform_dside_tracker_if #(
    parameter int NumChannels = 2
);
    import tiny_platform_cosim_pkg::*;

    logic [NumChannels-1:0]                req_i;
    logic [NumChannels-1:0]                gnt_i;
    logic [NumChannels-1:0]                we_i;
    logic [NumChannels-1:0][AddrWidth-1:0] addr_i;
    logic [NumChannels-1:0][BeWidth-1:0]   be_i;
    logic [NumChannels-1:0][DataWidth-1:0] wdata_i;
    logic [NumChannels-1:0]                misal_first_i;
    logic [NumChannels-1:0]                misal_second_i;
    logic [NumChannels-1:0]                rvalid_i;
    logic [NumChannels-1:0][DataWidth-1:0] rdata_i;
    logic [NumChannels-1:0]                err_i;

    modport master (
        output req_i, gnt_i, we_i, addr_i, be_i, wdata_i,
               misal_first_i, misal_second_i, rvalid_i, rdata_i, err_i
    );

    modport slave (
        input  req_i, gnt_i, we_i, addr_i, be_i, wdata_i,
               misal_first_i, misal_second_i, rvalid_i, rdata_i, err_i
    );

endinterface

// File: rtl/tiny_platform_dside_fifo.sv
// Per-channel in-order queue of granted requests, with occupancy count and sticky error flags.
// Latency: push visible at head one cycle later; head is read combinationally for the pop.
// Backpressure: none; a push into a full queue (no same-cycle pop) is dropped and flagged.
// Ports: i_push/i_push_dat enqueue, i_pop dequeue, o_head_dat head entry, o_pop_ok pop taken,
//        o_count occupancy, o_underflow/o_overflow sticky flags cleared by i_clear_err.
module tiny_platform_dside_fifo
    import tiny_platform_cosim_pkg::*;
#(
    parameter  int Depth = 4,
    localparam int PtrW  = $clog2(Depth),
    localparam int CntW  = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_push,
    input  dside_req_t      i_push_dat,
    input  logic            i_pop,
    input  logic            i_clear_err,
    output dside_req_t      o_head_dat,
    output logic            o_pop_ok,
    output logic [CntW-1:0] o_count,
    output logic            o_underflow,
    output logic            o_overflow
);

    dside_req_t      r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            r_underflow;
    logic            r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Occupancy comes from the count register, so equal pointers are never ambiguous.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CntW'(Depth));
    assign w_pop   = i_pop & ~w_empty;
    // A same-cycle pop frees the slot the push needs when full.
    assign w_push  = i_push & (~w_full | w_pop);

    // Head is read from the pre-edge array, so a pop never sees the same-cycle push.
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_pop_ok   = w_pop;
    assign o_count    = r_count;
    assign o_underflow = r_underflow;
    assign o_overflow  = r_overflow;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A fresh error takes priority over a clear in the same cycle.
            if (i_pop && w_empty)              r_underflow <= 1'b1;
            else if (i_clear_err)              r_underflow <= 1'b0;
            if (i_push && w_full && !i_pop)    r_overflow  <= 1'b1;
            else if (i_clear_err)              r_overflow  <= 1'b0;
        end
    end

endmodule

// File: rtl/tiny_platform_dside_tracker.sv
// Matches granted dmem requests to in-order responses on each channel and emits notify records.
// Latency: notify is registered, one cycle after the response; back-to-back responses stream.
// Backpressure: none; overflow/underflow are reported through sticky flags instead.
// Ports: clk_i/rst_ni, dmem (snooped bus, slave modport), clear_err_i; outputs ntf_valid_o,
//        ntf_o, outstanding_o, underflow_o, overflow_o (all per channel).
module tiny_platform_dside_tracker
    import tiny_platform_cosim_pkg::*;
#(
    parameter  int NumChannels    = 2,
    parameter  int MaxOutstanding = 4,
    localparam int CntW           = $clog2(MaxOutstanding) + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    tiny_platform_dside_tracker_if.slave        dmem,
    input  logic                                clear_err_i,
    output logic [NumChannels-1:0]              ntf_valid_o,
    output dside_rec_t [NumChannels-1:0]        ntf_o,
    output logic [NumChannels-1:0][CntW-1:0]    outstanding_o,
    output logic [NumChannels-1:0]              underflow_o,
    output logic [NumChannels-1:0]              overflow_o
);

    for (genvar ch = 0; ch < NumChannels; ch++) begin : g_ch
        dside_req_t w_push_dat;
        dside_req_t w_head;
        logic       w_pop_ok;
        logic       r_ntf_vld;
        dside_rec_t r_ntf;

        assign w_push_dat = '{
            we:    dmem.we_i[ch],
            addr:  dmem.addr_i[ch],
            be:    dmem.be_i[ch],
            wdata: dmem.wdata_i[ch],
            mis1:  dmem.misal_first_i[ch],
            mis2:  dmem.misal_second_i[ch]
        };

        tiny_platform_dside_fifo #(
            .Depth (MaxOutstanding)
        ) u_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .i_push      (dmem.req_i[ch] & dmem.gnt_i[ch]),
            .i_push_dat  (w_push_dat),
            .i_pop       (dmem.rvalid_i[ch]),
            .i_clear_err (clear_err_i),
            .o_head_dat  (w_head),
            .o_pop_ok    (w_pop_ok),
            .o_count     (outstanding_o[ch]),
            .o_underflow (underflow_o[ch]),
            .o_overflow  (overflow_o[ch])
        );

        // Stores report the data they wrote; loads report what came back.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_ntf_vld <= 1'b0;
                r_ntf     <= '0;
            end else begin
                r_ntf_vld <= w_pop_ok;
                if (w_pop_ok) begin
                    r_ntf <= '{
                        store: w_head.we,
                        addr:  w_head.addr,
                        data:  w_head.we ? w_head.wdata : dmem.rdata_i[ch],
                        be:    w_head.be,
                        err:   dmem.err_i[ch],
                        mis1:  w_head.mis1,
                        mis2:  w_head.mis2
                    };
                end
            end
        end

        assign ntf_valid_o[ch] = r_ntf_vld;
        assign ntf_o[ch]       = r_ntf;
    end

endmodule

// File: tb/tb_tiny_platform_dside_tracker.sv
// Directed, table-driven bench for the data-side tracker (2 channels, depth 4).
// Each table row drives one cycle on both channels and lists what must be seen just after the edge.
// Reset behaviour is exercised by hand-written sequences around the tables.
module tb_tiny_platform_dside_tracker;
    import tiny_platform_cosim_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_err_i = 1'b0;
    logic [1:0]           ntf_valid;
    dside_rec_t [1:0]     ntf;
    logic [1:0][2:0]      outstanding;
    logic [1:0]           underflow;
    logic [1:0]           overflow;

    tiny_platform_dside_tracker_if #(.NumChannels(2)) bus ();

    tiny_platform_dside_tracker #(
        .NumChannels    (2),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .dmem          (bus),
        .clear_err_i   (clear_err_i),
        .ntf_valid_o   (ntf_valid),
        .ntf_o         (ntf),
        .outstanding_o (outstanding),
        .underflow_o   (underflow),
        .overflow_o    (overflow)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req, gnt, we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        m1, m2;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_nv;
        logic [2:0]  e_cnt;
        logic        e_uf, e_of;
        logic        e_st;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_be;
        logic        e_err, e_m1, e_m2;
    } ch_vec_t;

    typedef struct {
        ch_vec_t c0;
        ch_vec_t c1;
        logic    clr;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic ch_vec_t idle();
        ch_vec_t v;
        v.req = 0; v.gnt = 0; v.we = 0; v.addr = '0; v.wdata = '0; v.be = '0;
        v.m1 = 0; v.m2 = 0; v.rv = 0; v.rdata = '0; v.err = 0;
        v.e_nv = 0; v.e_cnt = '0; v.e_uf = 0; v.e_of = 0; v.e_st = 0;
        v.e_addr = '0; v.e_data = '0; v.e_be = '0; v.e_err = 0; v.e_m1 = 0; v.e_m2 = 0;
        return v;
    endfunction

    function automatic ch_vec_t gr(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [3:0] be, input logic m1, input logic m2);
        ch_vec_t v = idle();
        v.req = 1; v.gnt = 1; v.we = we; v.addr = addr; v.wdata = wd; v.be = be;
        v.m1 = m1; v.m2 = m2;
        return v;
    endfunction

    // Request held without a grant: must not be tracked.
    function automatic ch_vec_t rqonly(input logic [31:0] addr);
        ch_vec_t v = idle();
        v.req = 1; v.addr = addr; v.be = 4'hF;
        return v;
    endfunction

    function automatic ch_vec_t rsp(input ch_vec_t vin, input logic [31:0] rd, input logic err);
        ch_vec_t v = vin;
        v.rv = 1; v.rdata = rd; v.err = err;
        return v;
    endfunction

    function automatic ch_vec_t ex(input ch_vec_t vin, input logic [2:0] cnt, input logic uf,
                                   input logic of);
        ch_vec_t v = vin;
        v.e_cnt = cnt; v.e_uf = uf; v.e_of = of;
        return v;
    endfunction

    function automatic ch_vec_t ic(input logic [2:0] cnt, input logic uf, input logic of);
        return ex(idle(), cnt, uf, of);
    endfunction

    function automatic ch_vec_t nt(input ch_vec_t vin, input logic st, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [3:0] be, input logic err,
                                   input logic m1, input logic m2);
        ch_vec_t v = vin;
        v.e_nv = 1; v.e_st = st; v.e_addr = addr; v.e_data = data; v.e_be = be;
        v.e_err = err; v.e_m1 = m1; v.e_m2 = m2;
        return v;
    endfunction

    function automatic void add(input ch_vec_t c0, input ch_vec_t c1, input logic clr);
        vec_t r;
        r.c0 = c0; r.c1 = c1; r.clr = clr;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input int ch, input ch_vec_t v);
        bus.req_i[ch]          = v.req;
        bus.gnt_i[ch]          = v.gnt;
        bus.we_i[ch]           = v.we;
        bus.addr_i[ch]         = v.addr;
        bus.be_i[ch]           = v.be;
        bus.wdata_i[ch]        = v.wdata;
        bus.misal_first_i[ch]  = v.m1;
        bus.misal_second_i[ch] = v.m2;
        bus.rvalid_i[ch]       = v.rv;
        bus.rdata_i[ch]        = v.rdata;
        bus.err_i[ch]          = v.err;
    endtask

    task automatic check(input int ch, input int idx, input ch_vec_t v);
        string p;
        p = $sformatf("v%0d ch%0d", idx, ch);
        chk({p, " ntf_valid"}, 32'(ntf_valid[ch]), 32'(v.e_nv));
        chk({p, " outstanding"}, 32'(outstanding[ch]), 32'(v.e_cnt));
        chk({p, " underflow"}, 32'(underflow[ch]), 32'(v.e_uf));
        chk({p, " overflow"}, 32'(overflow[ch]), 32'(v.e_of));
        if (v.e_nv) begin
            chk({p, " store"}, 32'(ntf[ch].store), 32'(v.e_st));
            chk({p, " addr"}, ntf[ch].addr, v.e_addr);
            chk({p, " data"}, ntf[ch].data, v.e_data);
            chk({p, " be"}, 32'(ntf[ch].be), 32'(v.e_be));
            chk({p, " err"}, 32'(ntf[ch].err), 32'(v.e_err));
            chk({p, " mis1"}, 32'(ntf[ch].mis1), 32'(v.e_m1));
            chk({p, " mis2"}, 32'(ntf[ch].mis2), 32'(v.e_m2));
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(0, tbl[i].c0);
            drive(1, tbl[i].c1);
            clear_err_i = tbl[i].clr;
            @(posedge clk_i);
            #1;
            check(0, i, tbl[i].c0);
            check(1, i, tbl[i].c1);
        end
        drive(0, idle());
        drive(1, idle());
        clear_err_i = 1'b0;
        tbl.delete();
    endtask

    initial begin
        drive(0, idle());
        drive(1, idle());
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("reset ntf_valid", 32'(ntf_valid), 32'd0);
        chk("reset ntf zero", 32'(|ntf), 32'd0);
        chk("reset outstanding", 32'(outstanding), 32'd0);
        chk("reset underflow", 32'(underflow), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);

        // Single load on ch0; ch1 request without grant must not be tracked.
        add(ex(gr(0, 32'h100, 32'h0, 4'hF, 0, 0), 3'd1, 0, 0), ex(rqonly(32'h900), 3'd0, 0, 0), 0);
        add(nt(ex(rsp(idle(), 32'hDEADBEEF, 0), 3'd0, 0, 0), 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0),
            ic(3'd0, 0, 0), 0);
        add(ic(3'd0, 0, 0), ic(3'd0, 0, 0), 0);

        // Four stores on ch1, then four responses: notify carries wdata, not rdata.
        for (int k = 0; k < 4; k++)
            add(ic(3'd0, 0, 0),
                ex(gr(1, 32'(32'h200 + 4 * k), 32'(32'hA0A0_0000 + k), 4'(1 << k), 0, 0), 3'(k + 1), 0, 0), 0);
        for (int k = 0; k < 4; k++)
            add(ic(3'd0, 0, 0),
                nt(ex(rsp(idle(), 32'h5555_5555, 0), 3'(3 - k), 0, 0),
                   1, 32'(32'h200 + 4 * k), 32'(32'hA0A0_0000 + k), 4'(1 << k), 0, 0, 0), 0);

        // Fill ch0, overflow on 5th grant, clear, then grant+response while full.
        for (int k = 0; k < 4; k++)
            add(ex(gr(0, 32'(32'h300 + 4 * k), 32'h0, 4'hF, 0, 0), 3'(k + 1), 0, 0), ic(3'd0, 0, 0), 0);
        add(ex(gr(0, 32'h310, 32'h0, 4'hF, 0, 0), 3'd4, 0, 1), ic(3'd0, 0, 0), 0);
        add(ic(3'd4, 0, 0), ic(3'd0, 0, 0), 1);
        add(nt(ex(rsp(gr(0, 32'h314, 32'h0, 4'hF, 0, 0), 32'h11, 0), 3'd4, 0, 0),
               0, 32'h300, 32'h11, 4'hF, 0, 0, 0), ic(3'd0, 0, 0), 0);
        for (int k = 0; k < 4; k++)
            add(nt(ex(rsp(idle(), 32'(32'h20 + k), 0), 3'(3 - k), 0, 0),
                   0, (k < 3) ? 32'(32'h304 + 4 * k) : 32'h314, 32'(32'h20 + k), 4'hF, 0, 0, 0),
                ic(3'd0, 0, 0), 0);

        // Underflow, clear, same-cycle grant+response on empty, error beating clear.
        add(ex(rsp(idle(), 32'h0, 0), 3'd0, 1, 0), ic(3'd0, 0, 0), 0);
        add(ic(3'd0, 0, 0), ic(3'd0, 0, 0), 1);
        add(ic(3'd0, 0, 0), ex(rsp(gr(0, 32'h500, 32'h0, 4'h3, 0, 0), 32'h77, 0), 3'd1, 1, 0), 0);
        add(ex(rsp(idle(), 32'h0, 0), 3'd0, 1, 0), ic(3'd1, 0, 0), 1);
        add(ic(3'd0, 0, 0),
            nt(ex(rsp(idle(), 32'h88, 0), 3'd0, 0, 0), 0, 32'h500, 32'h88, 4'h3, 0, 0, 0), 1);

        // Both channels respond together, bus error only on ch0.
        add(ex(gr(0, 32'h600, 32'h0, 4'hF, 0, 0), 3'd1, 0, 0),
            ex(gr(1, 32'h700, 32'hCAFEF00D, 4'hC, 0, 0), 3'd1, 0, 0), 0);
        add(nt(ex(rsp(idle(), 32'h1234_5678, 1), 3'd0, 0, 0), 0, 32'h600, 32'h1234_5678, 4'hF, 1, 0, 0),
            nt(ex(rsp(idle(), 32'h9999_9999, 0), 3'd0, 0, 0), 1, 32'h700, 32'hCAFEF00D, 4'hC, 0, 0, 0), 0);

        // Three loads in flight on ch0 before the reset below.
        for (int k = 0; k < 3; k++)
            add(ex(gr(0, 32'(32'h800 + 4 * k), 32'h0, 4'hF, 0, 0), 3'(k + 1), 0, 0), ic(3'd0, 0, 0), 0);
        run_tbl();

        // Asynchronous reset mid-operation.
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async rst outstanding ch0", 32'(outstanding[0]), 32'd0);
        chk("async rst ntf_valid", 32'(ntf_valid), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Stale response after reset, then a misaligned pair on ch1.
        add(ex(rsp(idle(), 32'h0, 0), 3'd0, 1, 0), ic(3'd0, 0, 0), 0);
        add(ic(3'd0, 1, 0), ex(gr(0, 32'h903, 32'h0, 4'h8, 1, 0), 3'd1, 0, 0), 0);
        add(ic(3'd0, 1, 0), ex(gr(0, 32'h904, 32'h0, 4'h7, 0, 1), 3'd2, 0, 0), 0);
        add(ic(3'd0, 1, 0),
            nt(ex(rsp(idle(), 32'hAA00_0000, 0), 3'd1, 0, 0), 0, 32'h903, 32'hAA00_0000, 4'h8, 0, 1, 0), 0);
        add(ic(3'd0, 1, 0),
            nt(ex(rsp(idle(), 32'h0000_00BB, 0), 3'd0, 0, 0), 0, 32'h904, 32'h0000_00BB, 4'h7, 0, 0, 1), 0);
        run_tbl();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
